// File: rtl/mfb_frame_lng_checker.sv
// MFB frame length checker: single-region pass-through with one register stage.
// Measures each frame in items, compares it with the expected length carried in
// the low bits of RX_META at SOF, and keeps saturating frame/error statistics
// plus a sticky flag for framing violations.
module mfb_frame_lng_checker #(
    parameter int REGION_SIZE = 2,
    parameter int BLOCK_SIZE  = 4,
    parameter int ITEM_WIDTH  = 8,
    parameter int META_WIDTH  = 36,
    parameter int LEN_WIDTH   = 32,
    parameter int CNT_WIDTH   = 32,
    localparam int DATA_WIDTH  = REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH,
    localparam int SOF_POS_W   = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
    localparam int EOF_POS_W   = (REGION_SIZE*BLOCK_SIZE > 1) ? $clog2(REGION_SIZE*BLOCK_SIZE) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,

    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [META_WIDTH-1:0] RX_META,
    input  logic [SOF_POS_W-1:0]  RX_SOF_POS,
    input  logic [EOF_POS_W-1:0]  RX_EOF_POS,
    input  logic                  RX_SOF,
    input  logic                  RX_EOF,
    input  logic                  RX_SRC_RDY,
    output logic                  RX_DST_RDY,

    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [META_WIDTH-1:0] TX_META,
    output logic [SOF_POS_W-1:0]  TX_SOF_POS,
    output logic [EOF_POS_W-1:0]  TX_EOF_POS,
    output logic                  TX_SOF,
    output logic                  TX_EOF,
    output logic                  TX_SRC_RDY,
    input  logic                  TX_DST_RDY,

    output logic                  ERR_VLD,
    output logic [LEN_WIDTH-1:0]  ERR_EXP,
    output logic [LEN_WIDTH-1:0]  ERR_GOT,
    output logic                  PROTO_ERR,
    output logic [CNT_WIDTH-1:0]  FRAME_CNT,
    output logic [CNT_WIDTH-1:0]  ERR_CNT
);

    localparam int WORD_ITEMS = REGION_SIZE*BLOCK_SIZE;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_IN_FRAME = 1'b1;

    // Adds two lengths and clamps to all-ones instead of wrapping.
    function automatic logic [LEN_WIDTH-1:0] satAdd(input logic [LEN_WIDTH-1:0] a,
                                                    input logic [LEN_WIDTH-1:0] b);
        logic [LEN_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] txData_q;
    logic [META_WIDTH-1:0] txMeta_q;
    logic [SOF_POS_W-1:0]  txSofPos_q;
    logic [EOF_POS_W-1:0]  txEofPos_q;
    logic                  txSof_q;
    logic                  txEof_q;
    logic                  txSrcRdy_q;

    logic [0:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  expLen_q, expLen_d;

    logic                  errVld_q;
    logic [LEN_WIDTH-1:0]  errExp_q;
    logic [LEN_WIDTH-1:0]  errGot_q;
    logic                  protoErr_q;
    logic [CNT_WIDTH-1:0]  frameCnt_q;
    logic [CNT_WIDTH-1:0]  errCnt_q;

    logic                  rxDstRdy;
    logic                  accept;
    logic [LEN_WIDTH-1:0]  sofItem;
    logic [LEN_WIDTH-1:0]  eofItem;
    logic [LEN_WIDTH-1:0]  metaLen;
    logic [LEN_WIDTH-1:0]  firstAcc;
    logic                  eofAfterSof;

    logic                  closeFrame;
    logic [LEN_WIDTH-1:0]  closeLen;
    logic [LEN_WIDTH-1:0]  closeExp;
    logic                  protoSet;

    assign rxDstRdy    = TX_DST_RDY | ~txSrcRdy_q;
    assign accept      = RX_SRC_RDY & rxDstRdy;
    assign sofItem     = LEN_WIDTH'(RX_SOF_POS) * LEN_WIDTH'(BLOCK_SIZE);
    assign eofItem     = LEN_WIDTH'(RX_EOF_POS);
    assign metaLen     = RX_META[LEN_WIDTH-1:0];
    assign firstAcc    = LEN_WIDTH'(WORD_ITEMS) - sofItem;
    assign eofAfterSof = (eofItem >= sofItem);

    // Output register stage: loads whenever it is empty or being drained downstream.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            txData_q   <= '0;
            txMeta_q   <= '0;
            txSofPos_q <= '0;
            txEofPos_q <= '0;
            txSof_q    <= 1'b0;
            txEof_q    <= 1'b0;
            txSrcRdy_q <= 1'b0;
        end else if (rxDstRdy) begin
            txData_q   <= RX_DATA;
            txMeta_q   <= RX_META;
            txSofPos_q <= RX_SOF_POS;
            txEofPos_q <= RX_EOF_POS;
            txSof_q    <= RX_SOF;
            txEof_q    <= RX_EOF;
            txSrcRdy_q <= RX_SRC_RDY;
        end
    end

    // Frame tracking: decides per accepted word whether a frame closes, opens or is violated.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        expLen_d   = expLen_q;
        closeFrame = 1'b0;
        closeLen   = '0;
        closeExp   = expLen_q;
        protoSet   = 1'b0;

        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (RX_SOF) begin
                    if (RX_EOF && eofAfterSof) begin
                        closeFrame = 1'b1;
                        closeLen   = eofItem - sofItem + LEN_WIDTH'(1);
                        closeExp   = metaLen;
                    end else begin
                        protoSet = RX_EOF;
                        expLen_d = metaLen;
                        acc_d    = firstAcc;
                        state_d  = ST_IN_FRAME;
                    end
                end else if (RX_EOF) begin
                    protoSet = 1'b1;
                end
            end else begin
                if (RX_SOF) begin
                    if (RX_EOF && !eofAfterSof) begin
                        closeFrame = 1'b1;
                        closeLen   = satAdd(acc_q, eofItem + LEN_WIDTH'(1));
                        closeExp   = expLen_q;
                    end else begin
                        protoSet = 1'b1;
                    end
                    expLen_d = metaLen;
                    acc_d    = firstAcc;
                end else if (RX_EOF) begin
                    closeFrame = 1'b1;
                    closeLen   = satAdd(acc_q, eofItem + LEN_WIDTH'(1));
                    closeExp   = expLen_q;
                    state_d    = ST_IDLE;
                end else begin
                    acc_d = satAdd(acc_q, LEN_WIDTH'(WORD_ITEMS));
                end
            end
        end
    end

    // Frame state and length accumulator.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            expLen_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            expLen_q <= expLen_d;
        end
    end

    // Length check results and saturating statistics, one cycle after the closing word.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            errVld_q   <= 1'b0;
            errExp_q   <= '0;
            errGot_q   <= '0;
            protoErr_q <= 1'b0;
            frameCnt_q <= '0;
            errCnt_q   <= '0;
        end else begin
            errVld_q <= 1'b0;
            if (protoSet) begin
                protoErr_q <= 1'b1;
            end
            if (closeFrame) begin
                if (frameCnt_q != {CNT_WIDTH{1'b1}}) begin
                    frameCnt_q <= frameCnt_q + CNT_WIDTH'(1);
                end
                if (closeLen != closeExp) begin
                    errVld_q <= 1'b1;
                    errExp_q <= closeExp;
                    errGot_q <= closeLen;
                    if (errCnt_q != {CNT_WIDTH{1'b1}}) begin
                        errCnt_q <= errCnt_q + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign RX_DST_RDY = rxDstRdy;
    assign TX_DATA    = txData_q;
    assign TX_META    = txMeta_q;
    assign TX_SOF_POS = txSofPos_q;
    assign TX_EOF_POS = txEofPos_q;
    assign TX_SOF     = txSof_q;
    assign TX_EOF     = txEof_q;
    assign TX_SRC_RDY = txSrcRdy_q;
    assign ERR_VLD    = errVld_q;
    assign ERR_EXP    = errExp_q;
    assign ERR_GOT    = errGot_q;
    assign PROTO_ERR  = protoErr_q;
    assign FRAME_CNT  = frameCnt_q;
    assign ERR_CNT    = errCnt_q;

endmodule

// File: doc/mfb_frame_lng_checker.md
Name: mfb_frame_lng_checker

Overview:
- Receive-side companion for MFB stream transformers: a single-region MFB sink/pass-through that measures every frame's length in items.
- Compares the measured length against the expected length carried in the low LEN_WIDTH bits of RX_META, which the producer sets at SOF.
- Sits at the output end of an MFB path, e.g. after a reconfigurator. Forwards the stream through one register stage and reports per-frame length errors, protocol errors and saturating statistics.

Parameters:
- REGION_SIZE, 2, blocks per word (MFB_REGIONS fixed to 1).
- BLOCK_SIZE, 4, items per block.
- ITEM_WIDTH, 8, bits per item.
- META_WIDTH, 36, metadata width; bits [LEN_WIDTH-1:0] hold the expected frame length in items.
- LEN_WIDTH, 32, length field and measured-length counter width.
- CNT_WIDTH, 32, statistic counter width.

Ports:
- CLK in 1: clock.
- RESET_N in 1: asynchronous, active-low reset.
- RX_DATA in REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH: input data word.
- RX_META in META_WIDTH: metadata, valid with RX_SOF.
- RX_SOF_POS in max(1,log2(REGION_SIZE)): block index of the SOF.
- RX_EOF_POS in max(1,log2(REGION_SIZE*BLOCK_SIZE)): item index of the EOF.
- RX_SOF in 1, RX_EOF in 1, RX_SRC_RDY in 1: frame flags and source ready.
- RX_DST_RDY out 1: ready toward the source.
- TX_DATA, TX_META, TX_SOF_POS, TX_EOF_POS, TX_SOF, TX_EOF, TX_SRC_RDY out: registered copy of RX; widths match the RX ports.
- TX_DST_RDY in 1: downstream ready.
- ERR_VLD out 1: one-cycle pulse when a frame length mismatch is detected.
- ERR_EXP out LEN_WIDTH: expected length of the failing frame.
- ERR_GOT out LEN_WIDTH: measured length of the failing frame.
- PROTO_ERR out 1: sticky protocol-violation flag.
- FRAME_CNT out CNT_WIDTH: number of completed frames.
- ERR_CNT out CNT_WIDTH: number of length mismatches.

Behaviour:
- Reset (async, RESET_N=0) clears:
  - TX_SRC_RDY, ERR_VLD, PROTO_ERR, FRAME_CNT, ERR_CNT, the in-frame state and the length accumulator.
  - ERR_EXP, ERR_GOT and the TX data fields reset to 0.
- Pass-through:
  - One pipeline register with latency 1; RX_DST_RDY = TX_DST_RDY or not TX_SRC_RDY.
  - A word is accepted when RX_SRC_RDY and RX_DST_RDY are both 1.
  - TX fields hold while TX_SRC_RDY=1 and TX_DST_RDY=0.
- Only accepted words update the checker. Let W = REGION_SIZE*BLOCK_SIZE and s = RX_SOF_POS*BLOCK_SIZE.
- FSM IDLE / IN_FRAME, per accepted word:
  - IDLE, no SOF, no EOF: stay; data outside a frame is ignored.
  - IDLE, EOF without a preceding SOF in this word: set PROTO_ERR; stay IDLE.
  - IDLE, SOF=1, EOF=1 with EOF_POS >= s (single-word frame): len = EOF_POS - s + 1; check; stay IDLE.
  - IDLE, SOF=1, EOF=0 or EOF_POS < s (the latter is also PROTO_ERR): capture expected length from META; acc = W - s; go to IN_FRAME.
  - IN_FRAME, no flags: acc += W.
  - IN_FRAME, EOF=1, SOF=0: len = acc + EOF_POS + 1; check; go to IDLE.
  - IN_FRAME, EOF=1, SOF=1, EOF_POS < s (end of a frame plus start of the next): close the current frame with len = acc + EOF_POS + 1; open the next with expected length from META and acc = W - s; stay IN_FRAME.
  - IN_FRAME, SOF=1 with EOF=0, or SOF=1 with EOF_POS >= s: PROTO_ERR. Restart the frame from this SOF (expected length from META, acc = W - s) and discard the old one; FRAME_CNT is not incremented.
- Check (registered, visible the cycle after acceptance):
  - FRAME_CNT += 1.
  - If len != expected: ERR_VLD = 1 for one cycle, ERR_EXP/ERR_GOT load, ERR_CNT += 1.
  - ERR_EXP/ERR_GOT hold the last error until the next error.
- Arithmetic:
  - acc is LEN_WIDTH bits and saturates at all-ones; a saturated acc always mismatches unless expected is all-ones.
  - Counters saturate at 2^CNT_WIDTH-1.
- PROTO_ERR clears only on reset.
- Reset mid-frame: the partial frame is dropped, nothing is counted, and the TX output is emptied.

Test Plan:
- Single-word frame SOF_POS=1, EOF_POS=6, META len=3 -> len 6-4+1=3; FRAME_CNT=1, ERR_VLD stays 0, TX word appears 1 cycle later.
- 3-word frame SOF_POS=0, EOF_POS=2, META len=18 -> 8+8+3=19 measured; ERR_VLD pulse, ERR_EXP=18, ERR_GOT=19, ERR_CNT=1.
- Back-to-back: word with EOF_POS=1 and SOF_POS=1 (prior acc=8, expected 10), next frame closes at EOF_POS=3 with META len 8 -> both pass, FRAME_CNT=2.
- Backpressure: TX_DST_RDY=0 for 5 cycles mid-frame -> RX_DST_RDY=0 after the register fills, TX fields stable, measured length unaffected.
- Protocol: EOF in IDLE -> PROTO_ERR=1 sticky, FRAME_CNT unchanged. SOF while IN_FRAME -> PROTO_ERR, old frame not counted.
- Assert RESET_N=0 mid-frame, then send a 5-item frame with META len=5 -> FRAME_CNT=1, ERR_CNT=0, PROTO_ERR=0.
